// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receive engine with a show-ahead RX FIFO.
//
// Samples the asynchronous rx line on the shared oversampling baud_tick,
// frames 5..DATA_W bit characters with optional parity and one or two stop
// bits, and stores each character with its parity/framing error flags.
//
// Ports:
//   clk, preset_n              clock, asynchronous active-low reset
//   baud_tick                  one-clk oversample enable (OVS per bit)
//   rx, rx_en                  serial input (async), receiver enable
//   cfg_data_bits/parity_en/parity_odd/stop2
//                              frame format, captured at start-bit detect
//   rd_en                      pop FIFO head
//   rd_data/rd_perr/rd_ferr    head entry (show-ahead, zero while empty)
//   rd_valid, fifo_full, fifo_level
//                              FIFO status
//   overrun, timeout, err_clr  sticky error flags and their clear
//   rts_n                      high when fifo_level >= RTS_THRESH
//   busy                       receiver FSM not idle
//
// Optional feature: define UART_RX_TIMEOUT_EN to build the character-timeout
// counter; without it timeout is tied low.

module uart_rx_param #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned OVS           = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned RTS_THRESH    = FIFO_DEPTH - 2,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                        clk,
  input  logic                        preset_n,
  input  logic                        baud_tick,
  input  logic                        rx,
  input  logic                        rx_en,
  input  logic [3:0]                  cfg_data_bits,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        cfg_stop2,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_perr,
  output logic                        rd_ferr,
  output logic                        rd_valid,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  input  logic                        err_clr,
  output logic                        timeout,
  output logic                        rts_n,
  output logic                        busy
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(OVS);
  localparam int unsigned BIT_IW = $clog2(DATA_W);
  localparam logic [3:0]  MAX_BITS = 4'(DATA_W);

  // Reject parameter sets the datapath cannot represent.
  if (DATA_W < 5 || DATA_W > 9 || OVS < 4 || (OVS % 2) != 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RTS_THRESH > FIFO_DEPTH ||
      TIMEOUT_CHARS == 0) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  typedef struct packed {
    logic              ferr;
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Receiver state
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_IW-1:0]   bit_q, bit_d;
  logic                stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [3:0]          bits_q, bits_d;
  logic                par_en_q, par_en_d;
  logic                par_odd_q, par_odd_d;
  logic                stop2_q, stop2_d;
  logic                rx_s1_q, rx_s2_q;
  logic                rx_prev_q, rx_prev_d;
  logic [3:0]          bits_eff_c;
  logic                cnt_last_c;
  logic                push_c;
  rx_entry_t           entry_c;

  // FIFO state
  rx_entry_t           mem_q [FIFO_DEPTH];
  rx_entry_t           head_c;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                valid_q, valid_d;
  logic                full_q, full_d;
  logic                rts_q, rts_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                pop_c, push_ok_c;

  // Out-of-range character lengths fall back to the maximum width.
  assign bits_eff_c = (cfg_data_bits < 4'd5 || cfg_data_bits > MAX_BITS) ? MAX_BITS
                                                                         : cfg_data_bits;
  assign cnt_last_c = (cnt_q == CNT_W'(OVS - 1));

  // Two-flop synchroniser, idle-high.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      bits_q     <= MAX_BITS;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  // Receiver next state; every decision is taken on a baud tick, except
  // rx_en low which aborts the frame immediately.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    rx_prev_d  = rx_prev_q;
    push_c     = 1'b0;

    // Line value at the previous tick, for falling-edge detection.
    if (baud_tick) rx_prev_d = rx_s2_q;

    if (!rx_en) begin
      state_d = S_IDLE;
    end else if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_d    = S_START;
            cnt_d      = '0;
            bit_d      = '0;
            stop_idx_d = 1'b0;
            data_d     = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            bits_d     = bits_eff_c;
            par_en_d   = cfg_parity_en;
            par_odd_d  = cfg_parity_odd;
            stop2_d    = cfg_stop2;
          end
        end
        S_START: begin
          if (cnt_q == CNT_W'(OVS / 2 - 1)) begin
            cnt_d   = '0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_last_c) begin
            cnt_d         = '0;
            data_d[bit_q] = rx_s2_q;
            if (bit_q == BIT_IW'(bits_q - 4'd1)) begin
              bit_d   = '0;
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + BIT_IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_last_c) begin
            cnt_d   = '0;
            perr_d  = ((^data_q) ^ rx_s2_q) != par_odd_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_last_c) begin
            cnt_d = '0;
            if (!rx_s2_q) ferr_d = 1'b1;
            if (stop2_q && !stop_idx_q) begin
              stop_idx_d = 1'b1;
            end else begin
              push_c  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ferr_d includes the stop sample taken on the push edge itself.
  always_comb begin
    entry_c      = '0;
    entry_c.ferr = ferr_d;
    entry_c.perr = perr_q;
    entry_c.data = data_q;
  end

  // FIFO control; a push into a full FIFO only lands if a pop frees a slot
  // on the same edge.
  always_comb begin
    pop_c     = rd_en && valid_q;
    push_ok_c = push_c && (!full_q || pop_c);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    valid_d   = (level_d != '0);
    full_d    = (level_d == LVL_W'(FIFO_DEPTH));
    rts_d     = (level_d >= LVL_W'(RTS_THRESH));
    overrun_d = overrun_q;
    if (err_clr) overrun_d = 1'b0;
    if (push_c && full_q && !pop_c) overrun_d = 1'b1;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      rts_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      rts_q     <= rts_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Storage array; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= entry_c;
  end

  assign head_c     = mem_q[rd_ptr_q];
  assign rd_data    = valid_q ? head_c.data : '0;
  assign rd_perr    = valid_q & head_c.perr;
  assign rd_ferr    = valid_q & head_c.ferr;
  assign rd_valid   = valid_q;
  assign fifo_full  = full_q;
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign rts_n      = rts_q;
  assign busy       = busy_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_MAX = TIMEOUT_CHARS * (DATA_W + 4) * OVS;
  localparam int unsigned TO_W   = $clog2(TO_MAX + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [TO_W-1:0] to_limit_c;
  logic [3:0]      frame_bits_c;
  logic            timeout_q, timeout_d;

  // Frame length in bits: start + data + optional parity + stop bits.
  assign frame_bits_c = 4'd1 + bits_eff_c + {3'b000, cfg_parity_en} + (cfg_stop2 ? 4'd2 : 4'd1);
  assign to_limit_c   = TO_W'(TIMEOUT_CHARS * OVS * 32'(frame_bits_c));

  // Idle tick counter; restarts on FIFO activity, saturates at the limit.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (pop_c || err_clr) timeout_d = 1'b0;
    if (push_c || pop_c) begin
      to_cnt_d = '0;
    end else if (valid_q && state_q == S_IDLE && baud_tick && to_cnt_q < to_limit_c) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == to_limit_c) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: frames are built bit by bit from
// the character format and the expected FIFO contents are kept in a queue.

module tb_uart_rx_param;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OVS      = 16;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned RTS_TH   = DEPTH - 2;
  localparam int unsigned TO_CHARS = 4;

  logic       clk;
  logic       preset_n;
  logic       baud_tick;
  logic       rx;
  logic       rx_en;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       rd_en;
  logic [DATA_W-1:0] rd_data;
  logic       rd_perr;
  logic       rd_ferr;
  logic       rd_valid;
  logic       fifo_full;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       overrun;
  logic       err_clr;
  logic       timeout;
  logic       rts_n;
  logic       busy;

  uart_rx_param #(
    .DATA_W(DATA_W), .OVS(OVS), .FIFO_DEPTH(DEPTH), .RTS_THRESH(RTS_TH), .TIMEOUT_CHARS(TO_CHARS)
  ) u_dut (
    .clk(clk), .preset_n(preset_n), .baud_tick(baud_tick), .rx(rx), .rx_en(rx_en),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2), .rd_en(rd_en),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_valid(rd_valid),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .overrun(overrun),
    .err_clr(err_clr), .timeout(timeout), .rts_n(rts_n), .busy(busy)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } exp_t;

  exp_t q[$];
  bit   m_overrun;
  int   tests;
  int   fails;
  int   tick_div;
  int   cal;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversample enable: one tick every tick_div clocks.
  initial begin
    int tcnt;
    tcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tcnt >= tick_div - 1) begin
        tcnt      = 0;
        baud_tick = 1'b1;
      end else begin
        tcnt      = tcnt + 1;
        baud_tick = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame on rx from the character format and record the entry
  // the receiver must store (or the overrun it must flag).
  task automatic send_frame(input logic [3:0] cfg_bits, input logic [DATA_W-1:0] data,
                            input bit par_en, input bit odd, input bit stop2,
                            input bit par_flip, input bit s1bad, input bit s2bad);
    int                eff;
    int                bc;
    logic [DATA_W-1:0] d;
    logic              par;
    exp_t              e;
    eff = (cfg_bits < 5 || cfg_bits > DATA_W) ? DATA_W : int'(cfg_bits);
    d   = '0;
    for (int i = 0; i < eff; i++) d[i] = data[i];
    par = (odd ? ~(^d) : ^d) ^ par_flip;
    bc  = OVS * tick_div;
    cfg_data_bits  = cfg_bits;
    cfg_parity_en  = par_en;
    cfg_parity_odd = odd;
    cfg_stop2      = stop2;
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < eff; i++) begin
      rx = d[i];
      repeat (bc) @(negedge clk);
    end
    if (par_en) begin
      rx = par;
      repeat (bc) @(negedge clk);
    end
    rx = ~s1bad;
    repeat (bc) @(negedge clk);
    if (stop2) begin
      rx = ~s2bad;
      repeat (bc) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * bc) @(negedge clk);
    e.data = d;
    e.perr = par_en & par_flip;
    e.ferr = s1bad | (stop2 & s2bad);
    if (q.size() < DEPTH) q.push_back(e);
    else m_overrun = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_level"}, 32'(fifo_level), q.size());
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    check_eq({tag, "_full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
    check_eq({tag, "_rts_n"}, 32'(rts_n), 32'(q.size() >= RTS_TH));
    check_eq({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Compare the show-ahead head with the model, then pop it.
  task automatic pop_check(input string tag);
    if (q.size() == 0) begin
      check_eq({tag, "_empty_valid"}, 32'(rd_valid), 0);
      return;
    end
    check_eq({tag, "_data"}, 32'(rd_data), 32'(q[0].data));
    check_eq({tag, "_perr"}, 32'(rd_perr), 32'(q[0].perr));
    check_eq({tag, "_ferr"}, 32'(rd_ferr), 32'(q[0].ferr));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    tests = 0; fails = 0; tick_div = 1; cal = 0; m_overrun = 1'b0;
    preset_n = 1'b0; rx = 1'b1; rx_en = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(rd_valid), 0);
    check_eq("rst_level", 32'(fifo_level), 0);
    check_eq("rst_full", 32'(fifo_full), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rts_n", 32'(rts_n), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_rd_flags", 32'({rd_perr, rd_ferr}), 0);
    preset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic 8N1 receive; also measure start-edge-to-push latency.
    fork
      send_frame(4'd8, 8'hA5, 0, 0, 0, 0, 0, 0);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (rd_valid) begin
            cal = k;
            break;
          end
        end
      end
    join
    check_eq("push_latency", 32'(cal >= 150 && cal <= 160), 1);
    if (cal < 2) cal = 155;
    check_state("basic");
    check_eq("basic_data", 32'(rd_data), 32'h A5);
    pop_check("basic");

    // 7E2 with wrong parity and a low second stop bit.
    send_frame(4'd7, 8'h41, 1, 0, 1, 1, 0, 1);
    check_state("pf");
    check_eq("pf_data", 32'(rd_data), 32'h41);
    check_eq("pf_flags", 32'({rd_perr, rd_ferr}), 32'h3);
    pop_check("pf");

    // False start: short low glitch.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("fs_busy_mid", 32'(busy), 1);
    repeat (30) @(negedge clk);
    check_state("false_start");

    // Random formats, data, error injection and tick rates.
    for (int n = 0; n < 20; n++) begin
      tick_div = int'($urandom_range(1, 3));
      send_frame(4'($urandom_range(3, 12)), DATA_W'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0));
      check_state($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) pop_check($sformatf("rand%0d_pop", n));
    end
    while (q.size() != 0) pop_check("rand_drain");
    check_state("rand_end");

    // Overrun: 17 frames, no reads.
    tick_div = 1;
    err_clr  = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    m_overrun = 1'b0;
    for (int v = 1; v <= 17; v++) begin
      send_frame(4'd8, DATA_W'(v), 0, 0, 0, 0, 0, 0);
      check_state($sformatf("ovr%0d", v));
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    m_overrun = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 0);

    // Push and pop on the same edge while full.
    fork
      send_frame(4'd8, 8'h12, 0, 0, 0, 0, 0, 0);
      begin
        repeat (cal - 1) @(negedge clk);
        check_eq("flow_head", 32'(rd_data), 32'(q[0].data));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(q.pop_front());
        check_eq("flow_level_edge", 32'(fifo_level), DEPTH);
        check_eq("flow_overrun_edge", 32'(overrun), 0);
      end
    join
    check_state("flow");
    while (q.size() != 0) pop_check("flow_drain");

    // rx_en dropped mid-frame.
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    rx = 1'b0;
    repeat (3 * OVS) @(negedge clk);
    check_eq("rxen_busy_before", 32'(busy), 1);
    rx_en = 1'b0;
    @(negedge clk);
    check_eq("rxen_busy_after", 32'(busy), 0);
    rx = 1'b1;
    repeat (12 * OVS) @(negedge clk);
    rx_en = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    check_state("rxen");

    // Character timeout after one byte and an idle line.
    fork
      send_frame(4'd8, 8'h5A, 0, 0, 0, 0, 0, 0);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (rd_valid) break;
        end
        check_eq("to_valid", 32'(rd_valid), 1);
        repeat (TO_CHARS * 10 * OVS - 10) @(negedge clk);
        check_eq("to_early", 32'(timeout), 0);
        repeat (20) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
        check_eq("to_set", 32'(timeout), 1);
`else
        check_eq("to_tied", 32'(timeout), 0);
`endif
      end
    join
    pop_check("to_pop");
    check_eq("to_clr", 32'(timeout), 0);

    // Asynchronous reset mid-frame with FIFO content.
    send_frame(4'd8, 8'h33, 0, 0, 0, 0, 0, 0);
    check_state("pre_rst");
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #1 preset_n = 1'b0;
    #1;
    check_eq("arst_level", 32'(fifo_level), 0);
    check_eq("arst_valid", 32'(rd_valid), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_rd_data", 32'(rd_data), 0);
    q.delete();
    rx = 1'b1;
    @(negedge clk);
    preset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
